// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: per-pipe result queues drained one entry per cycle, oldest first, into the RF write port.
// Optional build macro WB_FWD_EN adds the query_data forwarding mux; without it query_data is tied to zero.
module regfile_wb_arbiter #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              even_valid,
    output logic              even_ready,
    input  logic [ADDR_W-1:0] even_rt,
    input  logic [DATA_W-1:0] even_data,
    input  logic              odd_valid,
    output logic              odd_ready,
    input  logic [ADDR_W-1:0] odd_rt,
    input  logic [DATA_W-1:0] odd_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] query_reg,
    output logic              query_hit,
    output logic [DATA_W-1:0] query_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SEQ_W = $clog2(2 * DEPTH) + 1;

    // Index 0 is the even pipe, index 1 the odd pipe throughout.
    logic [ADDR_W-1:0] q_rt   [2][DEPTH];
    logic [DATA_W-1:0] q_data [2][DEPTH];
    logic [SEQ_W-1:0]  q_seq  [2][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [CNT_W-1:0]  cnt    [2];
    logic [SEQ_W-1:0]  seq_ctr;

    logic [ADDR_W-1:0] in_rt   [2];
    logic [DATA_W-1:0] in_data [2];
    logic [SEQ_W-1:0]  in_seq  [2];
    logic [ADDR_W-1:0] head_rt   [2];
    logic [DATA_W-1:0] head_data [2];
    logic [SEQ_W-1:0]  head_seq  [2];

    logic [1:0]        in_valid;
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        not_empty;
    logic [SEQ_W-1:0]  age_diff;
    logic              even_older;

    assign in_valid   = {odd_valid, even_valid};
    assign in_rt[0]   = even_rt;
    assign in_rt[1]   = odd_rt;
    assign in_data[0] = even_data;
    assign in_data[1] = odd_data;

    // Handshake: a result is taken on a rising edge where valid && ready.
    // ready depends only on occupancy (and is held low during reset), never on valid,
    // so a full queue stays not-ready even in a cycle where it also pops.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ready[p]     = reset && (cnt[p] != CNT_W'(DEPTH));
            not_empty[p] = (cnt[p] != '0);
            head_rt[p]   = q_rt[p][rd_ptr[p]];
            head_data[p] = q_data[p][rd_ptr[p]];
            head_seq[p]  = q_seq[p][rd_ptr[p]];
        end
    end

    assign even_ready = ready[0];
    assign odd_ready  = ready[1];
    assign push       = in_valid & ready;

    // Even is stamped first when both pipes are accepted in the same cycle.
    assign in_seq[0] = seq_ctr;
    assign in_seq[1] = seq_ctr + SEQ_W'(push[0]);

    // Modular age compare: a negative difference means the even head was stamped earlier.
    assign age_diff   = head_seq[0] - head_seq[1];
    assign even_older = age_diff[SEQ_W-1];

    assign pop[0] = not_empty[0] && (!not_empty[1] || even_older);
    assign pop[1] = not_empty[1] && !pop[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                cnt[p]    <= '0;
            end
            seq_ctr <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                end
                cnt[p] <= cnt[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            end
            seq_ctr <= seq_ctr + SEQ_W'(push[0]) + SEQ_W'(push[1]);
        end
    end

    // Entry storage carries no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                q_rt[p][wr_ptr[p]]   <= in_rt[p];
                q_data[p][wr_ptr[p]] <= in_data[p];
                q_seq[p][wr_ptr[p]]  <= in_seq[p];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_rt    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= |pop;
            if (pop[0]) begin
                rf_rt    <= head_rt[0];
                rf_wdata <= head_data[0];
            end else if (pop[1]) begin
                rf_rt    <= head_rt[1];
                rf_wdata <= head_data[1];
            end
        end
    end

    // slot_match[p][i]: the i-th oldest live entry of queue p targets query_reg.
    logic [DEPTH-1:0] slot_match [2];
    logic [1:0]       q_found;
    logic             out_hit;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            slot_match[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_match[p][i] = (CNT_W'(i) < cnt[p]) &&
                                   (q_rt[p][rd_ptr[p] + PTR_W'(i)] == query_reg);
            end
            q_found[p] = |slot_match[p];
        end
    end

    assign out_hit   = rf_we && (rf_rt == query_reg);
    assign query_hit = q_found[0] || q_found[1] || out_hit;

`ifdef WB_FWD_EN
    logic [DATA_W-1:0] fwd_data [2];
    logic [SEQ_W-1:0]  fwd_seq  [2];
    logic [SEQ_W-1:0]  fwd_diff;

    // Walking oldest to youngest, the last match per queue is that queue's youngest.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_data[p] = '0;
            fwd_seq[p]  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_match[p][i]) begin
                    fwd_data[p] = q_data[p][rd_ptr[p] + PTR_W'(i)];
                    fwd_seq[p]  = q_seq[p][rd_ptr[p] + PTR_W'(i)];
                end
            end
        end
    end

    assign fwd_diff = fwd_seq[0] - fwd_seq[1];

    always_comb begin
        query_data = '0;
        if (q_found[0] && q_found[1]) begin
            query_data = fwd_diff[SEQ_W-1] ? fwd_data[1] : fwd_data[0];
        end else if (q_found[0]) begin
            query_data = fwd_data[0];
        end else if (q_found[1]) begin
            query_data = fwd_data[1];
        end else if (out_hit) begin
            query_data = rf_wdata;
        end
    end
`else
    assign query_data = '0;
`endif

    a_even_cnt_bound: assert property (@(posedge clk) disable iff (!reset) cnt[0] <= CNT_W'(DEPTH));
    a_odd_cnt_bound:  assert property (@(posedge clk) disable iff (!reset) cnt[1] <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted results queue their expected RF write,
// a negedge monitor pops and compares every rf_we cycle; directed checks cover ready, latency, query and reset.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int W      = ADDR_W + DATA_W;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              even_valid;
    logic              even_ready;
    logic [ADDR_W-1:0] even_rt;
    logic [DATA_W-1:0] even_data;
    logic              odd_valid;
    logic              odd_ready;
    logic [ADDR_W-1:0] odd_rt;
    logic [DATA_W-1:0] odd_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rt;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] query_reg;
    logic              query_hit;
    logic [DATA_W-1:0] query_data;

    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      mon_w;
    logic [DATA_W-1:0] rf_model [2**ADDR_W];
    int                checks   = 0;
    int                failures = 0;
    int                first_e;
    int                first_o;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .even_valid (even_valid),
        .even_ready (even_ready),
        .even_rt    (even_rt),
        .even_data  (even_data),
        .odd_valid  (odd_valid),
        .odd_ready  (odd_ready),
        .odd_rt     (odd_rt),
        .odd_data   (odd_data),
        .rf_we      (rf_we),
        .rf_rt      (rf_rt),
        .rf_wdata   (rf_wdata),
        .query_reg  (query_reg),
        .query_hit  (query_hit),
        .query_data (query_data)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Driver: call at posedge+1; presents one cycle of inputs and returns at the next posedge+1.
    task automatic drive(input logic ev, input logic [ADDR_W-1:0] ert, input logic [DATA_W-1:0] ed,
                         input logic ov, input logic [ADDR_W-1:0] ort, input logic [DATA_W-1:0] od);
        even_valid = ev;
        even_rt    = ert;
        even_data  = ed;
        odd_valid  = ov;
        odd_rt     = ort;
        odd_data   = od;
        if (ev && even_ready) exp_q.push_back({ert, ed});
        if (ov && odd_ready)  exp_q.push_back({ort, od});
        @(posedge clk);
        #1;
        even_valid = 1'b0;
        odd_valid  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check(name, W'(exp_q.size()), W'(0));
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got write rt=%0d data=%0h required no write", rf_rt, rf_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                if ({rf_rt, rf_wdata} !== mon_w) begin
                    failures++;
                    $display("FAIL wb_order: got %0h required %0h", {rf_rt, rf_wdata}, mon_w);
                end
            end
            rf_model[rf_rt] = rf_wdata;
        end
    end

    initial begin
        reset      = 1'b1;
        even_valid = 1'b0;
        even_rt    = '0;
        even_data  = '0;
        odd_valid  = 1'b0;
        odd_rt     = '0;
        odd_data   = '0;
        query_reg  = '0;
        for (int i = 0; i < 2**ADDR_W; i++) rf_model[i] = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_even_ready", W'(even_ready), W'(0));
        check("rst_odd_ready",  W'(odd_ready),  W'(0));
        check("rst_rf_we",      W'(rf_we),      W'(0));
        check("rst_rf_rt",      W'(rf_rt),      W'(0));
        check("rst_rf_wdata",   W'(rf_wdata),   W'(0));
        check("rst_query_hit",  W'(query_hit),  W'(0));
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("release_even_ready", W'(even_ready), W'(1));
        check("release_odd_ready",  W'(odd_ready),  W'(1));
        @(posedge clk);
        #1;

        // Single write latency and query visibility
        query_reg = 7'd5;
        drive(1'b1, 7'd5, 128'hA, 1'b0, '0, '0);
        @(negedge clk);
        check("t1_we_after_accept", W'(rf_we), W'(0));
        check("t1_hit_queued",      W'(query_hit), W'(1));
        @(negedge clk);
        check("t1_we_after_pop", W'(rf_we),    W'(1));
        check("t1_rf_rt",        W'(rf_rt),    W'(5));
        check("t1_rf_wdata",     W'(rf_wdata), W'(128'hA));
        check("t1_hit_outstage", W'(query_hit), W'(1));
        @(negedge clk);
        check("t1_we_drop", W'(rf_we),     W'(0));
        check("t1_hit_gone", W'(query_hit), W'(0));
        @(posedge clk);
        #1;

        // Same-cycle push to the same register: even lands first, odd wins
        drive(1'b1, 7'd9, 128'd1, 1'b1, 7'd9, 128'd2);
        wait_drain("t2_drain");
        check("t2_reg9_final", W'(rf_model[9]), W'(2));

        // Odd streaming alone never back-pressures
        for (int i = 0; i < 10; i++) begin
            check("t3_odd_ready", W'(odd_ready), W'(1));
            drive(1'b0, '0, '0, 1'b1, 7'(40 + i), 128'h300 + 128'(i));
        end
        wait_drain("t3_drain");

        // Both pipes every cycle: odd fills first (cycle 6), even next (cycle 7)
        first_e = -1;
        first_o = -1;
        for (int c = 0; c < 20; c++) begin
            if (!even_ready && first_e < 0) first_e = c;
            if (!odd_ready && first_o < 0)  first_o = c;
            drive(1'b1, 7'(60 + c), 128'h400 + 128'(c), 1'b1, 7'(90 + c), 128'h500 + 128'(c));
        end
        check("t4_first_even_full", W'(first_e), W'(7));
        check("t4_first_odd_full",  W'(first_o), W'(6));
        wait_drain("t4_drain");

        // Query and forwarding priority
        drive(1'b1, 7'd3, 128'h11, 1'b1, 7'd3, 128'h22);
        query_reg = 7'd3;
        #1;
        check("t5_hit_both_queued",  W'(query_hit),  W'(1));
        check("t5_data_both_queued", W'(query_data), FWD ? W'(128'h22) : W'(0));
        query_reg = 7'd4;
        #1;
        check("t5_miss_hit",  W'(query_hit),  W'(0));
        check("t5_miss_data", W'(query_data), W'(0));
        query_reg = 7'd3;
        @(posedge clk);
        #1;
        check("t5_hit_queue_over_out",  W'(query_hit),  W'(1));
        check("t5_data_queue_over_out", W'(query_data), FWD ? W'(128'h22) : W'(0));
        @(posedge clk);
        #1;
        check("t5_hit_outstage",  W'(query_hit),  W'(1));
        check("t5_data_outstage", W'(query_data), FWD ? W'(128'h22) : W'(0));
        @(posedge clk);
        #1;
        check("t5_hit_retired",  W'(query_hit),  W'(0));
        check("t5_data_retired", W'(query_data), W'(0));
        drive(1'b1, 7'd7, 128'h77, 1'b1, 7'd3, 128'h33);
        drive(1'b1, 7'd3, 128'h44, 1'b0, '0, '0);
        check("t5_hit_even_younger",  W'(query_hit),  W'(1));
        check("t5_data_even_younger", W'(query_data), FWD ? W'(128'h44) : W'(0));
        wait_drain("t5_drain");

        // Reset mid-cycle with three entries queued and one in the output stage
        drive(1'b1, 7'd20, 128'h100, 1'b1, 7'd21, 128'h101);
        drive(1'b1, 7'd22, 128'h102, 1'b1, 7'd23, 128'h103);
        @(negedge clk);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rf_we_async",   W'(rf_we),      W'(0));
        check("t6_rf_rt_async",   W'(rf_rt),      W'(0));
        check("t6_rf_wdata_async", W'(rf_wdata),  W'(0));
        check("t6_even_ready_rst", W'(even_ready), W'(0));
        check("t6_odd_ready_rst",  W'(odd_ready),  W'(0));
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6_even_ready_rel", W'(even_ready), W'(1));
        check("t6_odd_ready_rel",  W'(odd_ready),  W'(1));
        query_reg = 7'd21;
        #1;
        check("t6_hit_cleared", W'(query_hit), W'(0));
        repeat (6) @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b1, 7'd11, 128'hBEEF);
        wait_drain("t6_post_reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
